// File: rtl/uart_wrapper.sv
// UART command wrapper: receives two-byte commands over RX, assembles them into cmd,
// and transmits single response bytes over TX. Receive and transmit run full duplex.
module uart_wrapper #(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int CNT_W = (BAUD_CYCLES > 2) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_CYCLES / 2 - 1);
  localparam logic [3:0]       LAST_BIT  = 4'd9;

  typedef enum logic {RX_IDLE, RX_RECV}  rx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT}  tx_state_t;

  // ---------------------------------------------------------------------------
  // RX synchronizer: both flops reset to the idle line level so that reset
  // release never looks like a start bit.
  logic rx_meta, rx_sync;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM. The baud counter counts down to the next sample point; the
  // first sample lands mid start bit, later ones mid bit. All 10 samples are
  // shifted into a 9-bit register so the data byte ends up in [7:0].
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_baud_cnt;
  logic [3:0]       rx_bit_cnt;
  logic [8:0]       rx_shift;
  logic             rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      rx_baud_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_shift    <= '0;
      rx_rdy      <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state    <= RX_RECV;
            rx_baud_cnt <= HALF_LAST;
            rx_bit_cnt  <= '0;
          end
        end
        RX_RECV: begin
          if (rx_baud_cnt == '0) begin
            rx_baud_cnt <= BAUD_LAST;
            rx_shift    <= {rx_sync, rx_shift[8:1]};
            if (rx_bit_cnt == LAST_BIT) begin
              rx_state   <= RX_IDLE;
              rx_bit_cnt <= '0;
              rx_rdy     <= 1'b1;
            end else begin
              rx_bit_cnt <= rx_bit_cnt + 4'd1;
            end
          end else begin
            rx_baud_cnt <= rx_baud_cnt - CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Command assembly: first byte goes high, second byte goes low and raises
  // cmd_rdy. A completing command outranks a simultaneous clear request.
  asm_state_t asm_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= ASM_HIGH;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      case (asm_state)
        ASM_HIGH: begin
          if (rx_rdy) begin
            cmd[15:8] <= rx_shift[7:0];
            cmd_rdy   <= 1'b0;
            asm_state <= ASM_LOW;
          end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
          end
        end
        ASM_LOW: begin
          if (rx_rdy) begin
            cmd[7:0]  <= rx_shift[7:0];
            cmd_rdy   <= 1'b1;
            asm_state <= ASM_HIGH;
          end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
          end
        end
        default: asm_state <= ASM_HIGH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM. TX is the LSB of a shift register that refills with ones,
  // so the line idles high once the stop bit has been shifted out.
  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_baud_cnt;
  logic [3:0]       tx_bit_cnt;
  logic [9:0]       tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_baud_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '1;
      tx_done     <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift    <= {1'b1, resp, 1'b0};
            tx_done     <= 1'b0;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_state    <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_baud_cnt == BAUD_LAST) begin
            tx_baud_cnt <= '0;
            tx_shift    <= {1'b1, tx_shift[9:1]};
            if (tx_bit_cnt == LAST_BIT) begin
              tx_bit_cnt <= '0;
              tx_done    <= 1'b1;
              tx_state   <= TX_IDLE;
            end else begin
              tx_bit_cnt <= tx_bit_cnt + 4'd1;
            end
          end else begin
            tx_baud_cnt <= tx_baud_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX = tx_shift[0];

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 SHALL have parameter BAUD_CYCLES, default 2604, clocks per UART bit (50 MHz / 19200 baud).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port RX, input, 1, serial data from the remote commander (idle high).
REQ-005 SHALL have port TX, output, 1, serial response to the remote commander (idle high).
REQ-006 SHALL have port cmd, output, 16, assembled command: {first byte, second byte}.
REQ-007 SHALL have port cmd_rdy, output, 1, level; a new 16-bit cmd is valid.
REQ-008 SHALL have port clr_cmd_rdy, input, 1, pulse from the consumer; clears cmd_rdy.
REQ-009 SHALL have port trmt, input, 1, pulse; start transmission of resp.
REQ-010 SHALL have port resp, input, 8, response byte; sampled only when trmt is accepted.
REQ-011 SHALL have port tx_done, output, 1, level; the last response frame is complete.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer; both flops reset high.
REQ-013 SHALL use frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-014 SHALL run a receive FSM with states IDLE and RECV; IDLE->RECV on the synchronized RX being low.
REQ-015 SHALL, in RECV, take the first sample BAUD_CYCLES/2 clocks after start detect, then sample every BAUD_CYCLES clocks, for 10 samples total.
REQ-016 SHALL, after the 10th sample (stop bit), return to IDLE and pulse an internal rx_rdy for exactly 1 clock; the stop-bit value is not checked and the byte is always accepted.
REQ-017 SHALL run an assembly FSM with states HIGH and LOW, where HIGH is the reset state.
REQ-018 SHALL, in HIGH on rx_rdy: store the byte in cmd[15:8], clear cmd_rdy, and go to LOW.
REQ-019 SHALL, in LOW on rx_rdy: store the byte in cmd[7:0], set cmd_rdy on the following clock edge, and go to HIGH.
REQ-020 SHALL impose no inter-byte timeout; LOW waits indefinitely for the second byte.
REQ-021 SHALL hold cmd_rdy until clr_cmd_rdy is high or a new first byte completes.
REQ-022 SHALL let set win over clr_cmd_rdy when both occur in the same cycle.
REQ-023 SHALL keep cmd stable while cmd_rdy=1, except for the high byte overwrite in REQ-018.
REQ-024 SHALL run a transmit FSM with states IDLE and XMIT; trmt in IDLE latches resp into a 10-bit shift register {1, resp, 0}.
REQ-025 SHALL drive TX low on the clock after trmt is accepted, and shift one bit every BAUD_CYCLES clocks, LSB first.
REQ-026 SHALL return the TX FSM to IDLE after 10 bit periods, with TX=1 and tx_done set in the same cycle.
REQ-027 SHALL clear tx_done when trmt is accepted.
REQ-028 SHALL ignore trmt while in XMIT; the frame in progress and its resp are unaltered.
REQ-029 SHALL run receive and transmit independently (full duplex), with no shared counters.
REQ-030 SHALL size the baud counters for BAUD_CYCLES (12 bits at default) and the bit counters at 4 bits.

Reset
REQ-031 SHALL, on rst_n low at any time: TX=1, cmd=0, cmd_rdy=0, tx_done=0, all FSMs to IDLE/HIGH, all counters 0.
REQ-032 SHALL discard any partially received byte or half-assembled command on reset; the next byte after reset is treated as the high byte.
REQ-033 SHALL resume operation on the first posedge clk after rst_n deasserts.

Verification
REQ-034 SHALL cover reset: assert rst_n=0 -> TX=1, cmd=0x0000, cmd_rdy=0, tx_done=0.
REQ-035 SHALL cover receive: drive bytes 0x12 then 0x34 at 2604 clk/bit -> cmd=0x1234, cmd_rdy=1 held; pulse clr_cmd_rdy -> cmd_rdy=0 on the next clock.
REQ-036 SHALL cover transmit: trmt with resp=0xA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 2604 clocks; tx_done=1 exactly 26040 clocks after TX falls.
REQ-037 SHALL cover trmt while busy: trmt with resp=0xFF mid-frame of 0xA5 -> TX frame unchanged, and tx_done asserts only once.
REQ-038 SHALL cover reset mid-command: send 0x55, pulse rst_n, then send 0xAB, 0xCD -> cmd=0xABCD, cmd_rdy=1.
REQ-039 SHALL cover full duplex and the same-cycle collision: transmit 0xA5 while receiving 0x00, 0x00 -> both complete correctly; clr_cmd_rdy coincident with the cmd_rdy set -> cmd_rdy=1.
